// File: rtl/mult_controller_if.sv
// mult_controller_if: handshake between the shift-add multiplier controller and its
// requester/datapath. master = controller side, slave = datapath/requester side.
`default_nettype none

interface mult_controller_if;
  logic start;
  logic Q0;
  logic zero;
  logic load_reg;
  logic add_reg;
  logic shift_reg;
  logic dec_p;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start, Q0, zero,
    output load_reg, add_reg, shift_reg, dec_p, busy, done, err
  );

  modport slave (
    output start, Q0, zero,
    input  load_reg, add_reg, shift_reg, dec_p, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/mult_controller.sv
// mult_controller: IDLE/LOAD/ADD/SHIFT/DONE sequencer for a BIT-wide shift-add multiplier.
// Rev 1.0 -- strobes registered from next state; iteration watchdog flags err with done.
`default_nettype none

module mult_controller #(
  parameter int BIT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_controller_if.master bus
);

  localparam int WD_W = $clog2(BIT + 1) + 1;
  localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WD_W-1:0] r_wd;
  logic            w_wd_fire;
  logic            r_load;
  logic            r_add_ph;
  logic            r_shift;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  // Watchdog fires on the SHIFT whose increment brings the count to BIT without zero seen.
  always_comb begin
    w_wd_fire = (r_state == S_SHIFT) && !bus.zero && (r_wd == C_WD_LAST);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = bus.start ? S_LOAD : S_IDLE;
      S_LOAD:  w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_SHIFT;
      S_SHIFT: w_state_nxt = (bus.zero || w_wd_fire) ? S_DONE : S_ADD;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they equal a decode of r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wd     <= '0;
      r_load   <= 1'b0;
      r_add_ph <= 1'b0;
      r_shift  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_load   <= (w_state_nxt == S_LOAD);
      r_add_ph <= (w_state_nxt == S_ADD);
      r_shift  <= (w_state_nxt == S_SHIFT);
      r_busy   <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_ADD) ||
                  (w_state_nxt == S_SHIFT);
      r_done   <= (w_state_nxt == S_DONE);
      r_err    <= (w_state_nxt == S_DONE) && w_wd_fire;
      if (r_state == S_LOAD) begin
        r_wd <= '0;
      end else if (r_state == S_SHIFT) begin
        r_wd <= r_wd + WD_W'(1);
      end
    end
  end

  assign bus.load_reg  = r_load;
  assign bus.add_reg   = r_add_ph & bus.Q0;
  assign bus.dec_p     = r_add_ph;
  assign bus.shift_reg = r_shift;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: doc/mult_controller.md
MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 Parameter BIT, default 5: operand width of the companion shift-add datapath; also the iteration bound.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset.
REQ-004 start  input  1  Request a multiply; sampled only in IDLE.
REQ-005 Q0  input  1  Datapath multiplier LSB (Q_reg[0]).
REQ-006 zero  input  1  Datapath iteration counter is zero (registered).
REQ-007 load_reg  output  1  Datapath load strobe: clear C/A, load B/Q, set counter to BIT.
REQ-008 add_reg  output  1  Datapath add strobe: {C,A} <= A+B.
REQ-009 shift_reg  output  1  Datapath right-shift strobe of {C,A,Q}.
REQ-010 dec_p  output  1  Datapath iteration counter decrement.
REQ-011 busy  output  1  High from the LOAD cycle through the last SHIFT cycle.
REQ-012 done  output  1  One-cycle pulse; product valid on the datapath in that cycle.
REQ-013 err  output  1  One-cycle pulse coincident with done when the iteration watchdog fired.

Function
REQ-014 FSM states shall be IDLE, LOAD, ADD, SHIFT and DONE, held in a state register updated on posedge clk.
REQ-015 IDLE: all strobes low; start=1 -> LOAD, else stay in IDLE.
REQ-016 LOAD: load_reg=1 for exactly one cycle; next state is ADD.
REQ-017 ADD: dec_p=1; add_reg=Q0 (combinational); next state is SHIFT.
REQ-018 SHIFT: shift_reg=1; next state is DONE if zero=1 or the watchdog has expired, else ADD.
REQ-019 DONE: done=1 for one cycle; next state is IDLE unconditionally.
REQ-020 Strobes shall be decoded from the current state (Moore), except add_reg, which also depends on Q0; at most one of load_reg/add_reg/shift_reg is high in any cycle.
REQ-021 Latency: start sampled at edge k; LOAD occupies cycle k+1; exactly BIT ADD/SHIFT pairs follow; done is high in cycle k+2+2*BIT.
REQ-022 Watchdog: an internal counter of width clog2(BIT+1)+1 is cleared in LOAD and incremented in each SHIFT.
REQ-023 If the counter reaches BIT in SHIFT while zero=0, the FSM shall go to DONE and assert err together with done.
REQ-024 start in any state other than IDLE shall be ignored, with no queuing.
REQ-025 start held high continuously shall begin a new operation on the edge after DONE returns to IDLE, giving one IDLE cycle between operations.
REQ-026 Q0 and zero shall be ignored outside ADD and SHIFT respectively.

Reset
REQ-027 rst_n=0 shall immediately force state=IDLE, watchdog=0, and drive load_reg, add_reg, shift_reg, dec_p, busy, done and err to 0, independent of clk.
REQ-028 Reset asserted mid-operation shall abort with no done pulse; after release the block waits for a new start in IDLE.
REQ-029 Release of rst_n shall take effect at the first rising clk edge after deassertion.

Verification (BIT=5, controller connected to the datapath)
REQ-030 B=13, Q=11, start pulse -> product=143 with done in cycle k+12; add_reg high in exactly 3 ADD cycles; err=0.
REQ-031 B=31, Q=31 -> product=961; add_reg asserted in all 5 ADD cycles; C carry exercised.
REQ-032 B=0, Q=0 -> product=0; add_reg never high; done still at k+12.
REQ-033 start pulsed during SHIFT of a running operation -> ignored; exactly one done; product unchanged.
REQ-034 rst_n low during the third ADD -> all outputs 0 asynchronously; no done; new start after release yields the correct product.
REQ-035 Stubbed datapath with zero tied to 0 -> done and err pulse together after the fifth SHIFT; FSM returns to IDLE.
